seg_scan_capture: RTL

- Receiving end of the 4-digit multiplexed seven-segment bus (anode/cathode) driven by the stopwatch display scanner.
- Samples the bus each fast_clk cycle, decodes segment patterns back to BCD digits, reassembles complete scans (AN3→AN0), and publishes the captured time with integrity flags.
- Used as a board-level display readback/self-check and as a scoreboard front end in simulation.

---
 rtl/seg_scan_capture.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// Display bus readback: decodes the multiplexed 4-digit seven-segment bus,
// reassembles AN3..AN0 scans, and publishes good frames with integrity pulses.
// Ports:
//   fast_clk, RESET   scan clock, async active-high reset
//   anode[3:0]        active-low digit enables (bit3 = minute tens)
//   cathode[6:0]      active-low segments (bit0 = a .. bit6 = g)
//   min_tens..sec_ones  last good captured BCD digits
//   minutes, seconds  binary values of the published digits
//   frame_valid, frame_changed, seg_err, seq_err, gap_err  one-cycle pulses
//   frame_count       good-frame counter, wraps
module seg_scan_capture #(
    parameter int unsigned MAX_GAP = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             fast_clk,
    input  logic             RESET,
    input  logic [3:0]       anode,
    input  logic [6:0]       cathode,
    output logic [3:0]       min_tens,
    output logic [3:0]       min_ones,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic [5:0]       minutes,
    output logic [5:0]       seconds,
    output logic             frame_valid,
    output logic             frame_changed,
    output logic             seg_err,
    output logic             seq_err,
    output logic             gap_err,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned GAP_W = $clog2(MAX_GAP + 2);

    typedef enum logic [1:0] {HUNT, GOT3, GOT2, GOT1} state_t;

    state_t           state, state_n;
    logic [3:0]       sh3, sh2, sh1, sh3_n, sh2_n, sh1_n;
    logic             bad_flag, bad_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;

    logic [3:0]       min_tens_n, min_ones_n, sec_tens_n, sec_ones_n;
    logic [5:0]       minutes_n, seconds_n;
    logic             frame_valid_n, frame_changed_n, seg_err_n, seq_err_n, gap_err_n;
    logic [CNT_W-1:0] frame_count_n;

    logic [3:0]       dig;
    logic             dig_bad;
    logic [3:0]       exp_an;

    // Active-low segment pattern to BCD; anything unrecognised maps to 4'hF.
    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] d;
        case (seg)
            7'b1000000: d = 4'd0;
            7'b1111001: d = 4'd1;
            7'b0100100: d = 4'd2;
            7'b0110000: d = 4'd3;
            7'b0011001: d = 4'd4;
            7'b0010010: d = 4'd5;
            7'b0000010: d = 4'd6;
            7'b1111000: d = 4'd7;
            7'b0000000: d = 4'd8;
            7'b0010000: d = 4'd9;
            default:    d = 4'hF;
        endcase
        return d;
    endfunction

    // State and all published outputs.
    always_ff @(posedge fast_clk or posedge RESET) begin
        if (RESET) begin
            state         <= HUNT;
            sh3           <= '0;
            sh2           <= '0;
            sh1           <= '0;
            bad_flag      <= 1'b0;
            gap_cnt       <= '0;
            min_tens      <= '0;
            min_ones      <= '0;
            sec_tens      <= '0;
            sec_ones      <= '0;
            minutes       <= '0;
            seconds       <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            seg_err       <= 1'b0;
            seq_err       <= 1'b0;
            gap_err       <= 1'b0;
            frame_count   <= '0;
        end else begin
            state         <= state_n;
            sh3           <= sh3_n;
            sh2           <= sh2_n;
            sh1           <= sh1_n;
            bad_flag      <= bad_n;
            gap_cnt       <= gap_n;
            min_tens      <= min_tens_n;
            min_ones      <= min_ones_n;
            sec_tens      <= sec_tens_n;
            sec_ones      <= sec_ones_n;
            minutes       <= minutes_n;
            seconds       <= seconds_n;
            frame_valid   <= frame_valid_n;
            frame_changed <= frame_changed_n;
            seg_err       <= seg_err_n;
            seq_err       <= seq_err_n;
            gap_err       <= gap_err_n;
            frame_count   <= frame_count_n;
        end
    end

    // Next state, shadow capture and frame publication.
    always_comb begin
        state_n         = state;
        sh3_n           = sh3;
        sh2_n           = sh2;
        sh1_n           = sh1;
        bad_n           = bad_flag;
        gap_n           = gap_cnt;
        min_tens_n      = min_tens;
        min_ones_n      = min_ones;
        sec_tens_n      = sec_tens;
        sec_ones_n      = sec_ones;
        minutes_n       = minutes;
        seconds_n       = seconds;
        frame_valid_n   = 1'b0;
        frame_changed_n = 1'b0;
        seg_err_n       = 1'b0;
        seq_err_n       = 1'b0;
        gap_err_n       = 1'b0;
        frame_count_n   = frame_count;

        dig     = seg_decode(cathode);
        dig_bad = (dig == 4'hF);

        case (state)
            GOT3:    exp_an = 4'b1011;
            GOT2:    exp_an = 4'b1101;
            default: exp_an = 4'b1110;
        endcase

        if (state == HUNT) begin
            gap_n = '0;
            if (anode == 4'b0111) begin
                sh3_n   = dig;
                bad_n   = dig_bad;
                state_n = GOT3;
            end
        end else if (anode == 4'b1111) begin
            // Blank inside a scan: tolerated up to MAX_GAP consecutive cycles.
            if (gap_cnt == GAP_W'(MAX_GAP)) begin
                gap_err_n = 1'b1;
                gap_n     = '0;
                state_n   = HUNT;
            end else begin
                gap_n = gap_cnt + GAP_W'(1);
            end
        end else if (anode == exp_an) begin
            gap_n = '0;
            case (state)
                GOT3: begin
                    sh2_n   = dig;
                    bad_n   = bad_flag | dig_bad;
                    state_n = GOT2;
                end
                GOT2: begin
                    // Seconds tens above 5 is not a legal clock value.
                    sh1_n   = dig;
                    bad_n   = bad_flag | dig_bad | (dig > 4'd5);
                    state_n = GOT1;
                end
                default: begin
                    state_n = HUNT;
                    if (bad_flag || dig_bad) begin
                        seg_err_n = 1'b1;
                    end else begin
                        min_tens_n      = sh3;
                        min_ones_n      = sh2;
                        sec_tens_n      = sh1;
                        sec_ones_n      = dig;
                        minutes_n       = 6'(sh3) * 6'd10 + 6'(sh2);
                        seconds_n       = 6'(sh1) * 6'd10 + 6'(dig);
                        frame_valid_n   = 1'b1;
                        frame_changed_n = (sh3 != min_tens) || (sh2 != min_ones) ||
                                          (sh1 != sec_tens) || (dig != sec_ones);
                        frame_count_n   = frame_count + CNT_W'(1);
                    end
                end
            endcase
        end else begin
            // Out-of-order or multi-hot anode; AN3 restarts a scan immediately.
            gap_n     = '0;
            seq_err_n = 1'b1;
            if (anode == 4'b0111) begin
                sh3_n   = dig;
                bad_n   = dig_bad;
                state_n = GOT3;
            end else begin
                state_n = HUNT;
            end
        end
    end

endmodule
